// File: rtl/color_button_if.sv
// Button-to-colour bus between the raw button pins, the frame timing
// and the colour-level consumer.
interface color_button_if;
  logic       btn_r;
  logic       btn_g;
  logic       btn_b;
  logic       frame_start;
  logic [3:0] level_r;
  logic [3:0] level_g;
  logic [3:0] level_b;
  logic [2:0] pressed;
  logic [2:0] step;

  modport master (
    output btn_r, btn_g, btn_b, frame_start,
    input  level_r, level_g, level_b, pressed, step
  );

  modport slave (
    input  btn_r, btn_g, btn_b, frame_start,
    output level_r, level_g, level_b, pressed, step
  );
endinterface

// File: rtl/color_button_ctrl.sv
// Debounced RGB push-buttons with auto-repeat driving three 4-bit
// colour levels that only change at frame start.
module color_button_ctrl #(
  parameter int DB_CYCLES    = 250000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000,
  parameter bit WRAP         = 1'b1
) (
  input logic           clk,
  input logic           rst,
  color_button_if.slave bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES);
  localparam logic [23:0] RD_LAST = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] RR_LAST = 24'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_e;

  logic [2:0]    btn;
  logic [2:0]    s1_q;
  logic [2:0]    s2_q;
  logic [2:0]    pressed_q;
  logic [2:0]    pressed_d;
  logic [CW-1:0] cnt_q     [3];
  logic [CW-1:0] cnt_d     [3];
  logic [3:0]    pending_q [3];
  logic [3:0]    pending_d [3];
  logic [3:0]    level_q   [3];
  logic [3:0]    level_d   [3];
  logic [2:0]    step;

  assign btn = {bus.btn_b, bus.btn_g, bus.btn_r};

  // Counter runs while s2 disagrees with the accepted level; any
  // agreement restarts the stability window.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pressed_d[i] = pressed_q[i];
      cnt_d[i]     = '0;
      if (s2_q[i] != pressed_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          pressed_d[i] = ~pressed_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      pending_d[i] = pending_q[i];
      if (step[i]) begin
        if (pending_q[i] == 4'hF && !WRAP) begin
          pending_d[i] = 4'hF;
        end else begin
          pending_d[i] = pending_q[i] + 4'd1;
        end
      end
      level_d[i] = bus.frame_start ? pending_q[i] : level_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      pressed_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]     <= '0;
        pending_q[i] <= '0;
        level_q[i]   <= '0;
      end
    end else begin
      s1_q      <= btn;
      s2_q      <= s1_q;
      pressed_q <= pressed_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]     <= cnt_d[i];
        pending_q[i] <= pending_d[i];
        level_q[i]   <= level_d[i];
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_e      state_q;
    logic [23:0] timer_q;
    logic        step_q;

    // Release is tested first so it wins over a same-cycle expiry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        timer_q <= '0;
        step_q  <= 1'b0;
      end else begin
        step_q <= 1'b0;
        unique case (state_q)
          IDLE: begin
            if (pressed_q[g]) begin
              step_q  <= 1'b1;
              state_q <= HOLD;
              timer_q <= '0;
            end
          end
          HOLD: begin
            if (!pressed_q[g]) begin
              state_q <= IDLE;
            end else if (timer_q == RD_LAST) begin
              step_q  <= 1'b1;
              state_q <= REPEAT;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 24'd1;
            end
          end
          REPEAT: begin
            if (!pressed_q[g]) begin
              state_q <= IDLE;
            end else if (timer_q == RR_LAST) begin
              step_q  <= 1'b1;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 24'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign step[g] = step_q;
  end

  assign bus.level_r = level_q[0];
  assign bus.level_g = level_q[1];
  assign bus.level_b = level_q[2];
  assign bus.pressed = pressed_q;
  assign bus.step    = step;

endmodule

// File: tb/tb_color_button_ctrl.sv
// Bench for color_button_ctrl: wrapping and saturating instances share
// stimulus and are checked every cycle against a window/age model.
module tb_color_button_ctrl;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  color_button_if ifw ();
  color_button_if ifs ();

  assign ifs.btn_r       = ifw.btn_r;
  assign ifs.btn_g       = ifw.btn_g;
  assign ifs.btn_b       = ifw.btn_b;
  assign ifs.frame_start = ifw.frame_start;

  color_button_ctrl #(
    .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1'b1)
  ) dut_wrap (
    .clk(clk), .rst(rst), .bus(ifw.slave)
  );

  color_button_ctrl #(
    .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1'b0)
  ) dut_sat (
    .clk(clk), .rst(rst), .bus(ifs.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fcnt  = 0;
  int stepcnt[3];

  // Model: a level is accepted once the last DB+1 synchronised samples
  // all disagree with it; steps follow from time held since acceptance.
  logic [15:0] hist[3];
  bit          pm[3];
  bit          sm[3];
  int          age[3];
  int          pw[3];
  int          ps[3];
  int          lw[3];
  int          ls[3];
  logic [2:0]  bv;
  logic [DB:0] win;
  bit          nxt;

  function automatic bit rep_hit(int a);
    return (a == 1) || (a == RD + 1) ||
           (a > RD + 1 && (a - 1 - RD) % RR == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        hist[i] = '0; pm[i] = 0; sm[i] = 0; age[i] = 0;
        pw[i] = 0; ps[i] = 0; lw[i] = 0; ls[i] = 0;
      end
    end else begin
      bv = {ifw.btn_b, ifw.btn_g, ifw.btn_r};
      for (int i = 0; i < 3; i++) begin
        if (ifw.frame_start) begin
          lw[i] = pw[i];
          ls[i] = ps[i];
        end
        if (sm[i]) begin
          pw[i] = (pw[i] + 1) % 16;
          ps[i] = (ps[i] < 15) ? ps[i] + 1 : 15;
        end
        nxt = 0;
        if (pm[i]) begin
          age[i] = age[i] + 1;
          nxt = rep_hit(age[i]);
        end
        sm[i] = nxt;
        hist[i] = {hist[i][14:0], bv[i]};
        win = hist[i][DB+2:2];
        if (pm[i] ? (win == '0) : (&win)) begin
          pm[i]  = !pm[i];
          age[i] = 0;
        end
      end
    end
  end

  task automatic check(string tag);
    logic [17:0] ew, es, ow, os;
    ew = {4'(lw[2]), 4'(lw[1]), 4'(lw[0]),
          pm[2], pm[1], pm[0], sm[2], sm[1], sm[0]};
    es = {4'(ls[2]), 4'(ls[1]), 4'(ls[0]),
          pm[2], pm[1], pm[0], sm[2], sm[1], sm[0]};
    ow = {ifw.level_b, ifw.level_g, ifw.level_r, ifw.pressed, ifw.step};
    os = {ifs.level_b, ifs.level_g, ifs.level_r, ifs.pressed, ifs.step};
    n_cmp++;
    assert (ow === ew) else begin
      n_bad++;
      $error("FAIL %s_wrap: observed %h expected %h", tag, ow, ew);
    end
    n_cmp++;
    assert (os === es) else begin
      n_bad++;
      $error("FAIL %s_sat: observed %h expected %h", tag, os, es);
    end
  endtask

  task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("cyc");
    for (int i = 0; i < 3; i++) stepcnt[i] += int'(ifw.step[i]);
    fcnt++;
    ifw.frame_start = (fcnt % 20 == 0);
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clr_steps();
    for (int i = 0; i < 3; i++) stepcnt[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    {ifw.btn_b, ifw.btn_g, ifw.btn_r} = 3'b000;
    rst = 1'b0;
  endtask

  task automatic mid_reset(string tag);
    #3 rst = 1'b1;
    #1 check(tag);
    expect_eq({tag, "_zero"},
              {14'd0, ifw.level_b, ifw.level_g, ifw.level_r,
               ifw.pressed, ifw.step}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int run[3];
    logic [2:0] rb;

    {ifw.btn_b, ifw.btn_g, ifw.btn_r} = 3'b000;
    ifw.frame_start = 1'b0;
    clr_steps();
    #1 rst = 1'b1;
    ticks(3);
    expect_eq("por_levels",
              {20'd0, ifw.level_b, ifw.level_g, ifw.level_r}, 32'd0);
    rst = 1'b0;

    // 1: asynchronous reset with buttons toggling
    for (int k = 0; k < 15; k++) begin
      {ifw.btn_b, ifw.btn_g, ifw.btn_r} = 3'($urandom);
      tick();
    end
    mid_reset("rst_async");
    tick();
    {ifw.btn_b, ifw.btn_g, ifw.btn_r} = 3'b000;
    rst = 1'b0;
    clr_steps();
    ticks(30);
    expect_eq("rst_idle_steps", stepcnt[0] + stepcnt[1] + stepcnt[2], 0);
    expect_eq("rst_idle_lvl",
              {20'd0, ifw.level_b, ifw.level_g, ifw.level_r}, 32'd0);

    // 2: single clean press, latency and commit
    clr_steps();
    first = -1;
    ifw.btn_r = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ifw.step[0] && first < 0) first = k;
      if (k == 10) ifw.btn_r = 1'b0;
    end
    expect_eq("press_latency", first, DB + 4);
    expect_eq("press_steps", stepcnt[0], 1);
    expect_eq("press_lvl_r", ifw.level_r, 1);
    expect_eq("press_lvl_gb", {ifw.level_b, ifw.level_g}, 0);

    // 3: bounce rejection on green
    clr_steps();
    for (int k = 0; k < 40; ) begin
      int h, l;
      h = $urandom_range(1, 3);
      l = $urandom_range(1, 3);
      ifw.btn_g = 1'b1;
      ticks(h);
      ifw.btn_g = 1'b0;
      ticks(l);
      k += h + l;
    end
    ticks(25);
    expect_eq("bounce_steps", stepcnt[1], 0);
    expect_eq("bounce_lvl_g", ifw.level_g, 0);

    // 4: auto-repeat on blue
    do_reset();
    clr_steps();
    ifw.btn_b = 1'b1;
    ticks(30);
    ifw.btn_b = 1'b0;
    ticks(30);
    expect_eq("repeat_steps", stepcnt[2], 8);
    expect_eq("repeat_lvl_b", ifw.level_b, 8);

    // 5: wrap versus saturate after 17 presses
    do_reset();
    clr_steps();
    for (int p = 0; p < 17; p++) begin
      ifw.btn_r = 1'b1;
      ticks(8);
      ifw.btn_r = 1'b0;
      ticks(10);
    end
    ticks(25);
    expect_eq("wrap_steps", stepcnt[0], 17);
    expect_eq("wrap_lvl_r", ifw.level_r, 1);
    expect_eq("sat_lvl_r", ifs.level_r, 15);

    // 6: step coinciding with frame_start, then reset inside REPEAT
    do_reset();
    for (int k = 0; k < 20 && (fcnt % 20) != 12; k++) tick();
    ifw.btn_r = 1'b1;
    ticks(8);
    ifw.btn_r = 1'b0;
    tick();
    expect_eq("coinc_step", ifw.frame_start, 0);
    expect_eq("coinc_lvl_hold", ifw.level_r, 0);
    ticks(20);
    expect_eq("coinc_lvl_next", ifw.level_r, 1);

    ifw.btn_r = 1'b1;
    ticks(25);
    mid_reset("rst_repeat");
    tick();
    ifw.btn_r = 1'b0;
    rst = 1'b0;
    clr_steps();
    ticks(30);
    expect_eq("rst_repeat_steps", stepcnt[0], 0);
    expect_eq("rst_repeat_lvl", ifw.level_r, 0);

    // random phase
    do_reset();
    rb = 3'b000;
    for (int i = 0; i < 3; i++) run[i] = 0;
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (run[i] == 0) begin
          rb[i] = ~rb[i];
          run[i] = ($urandom % 2) ? $urandom_range(1, 4)
                                  : $urandom_range(5, 45);
        end
        run[i]--;
      end
      {ifw.btn_b, ifw.btn_g, ifw.btn_r} = rb;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
